// File: rtl/avst_pkt_gen.sv
// Avalon-ST synthetic frame source: programmable frame count, length and
// inter-packet gap, with a deterministic incrementing payload and progress counters.
module avst_pkt_gen #(
  parameter int WORDS       = 1,
  parameter int WIDTH       = 64,
  parameter int EMPTY_WIDTH = 3
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     start_i,
  input  logic                     stop_i,
  input  logic [15:0]              pkt_len_i,
  input  logic [31:0]              pkt_cnt_i,
  input  logic [7:0]               ipg_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [31:0]              pkt_sent_o,
  output logic [47:0]              byte_sent_o,
  output logic                     avst_valid_o,
  output logic [WIDTH*WORDS-1:0]   avst_data_o,
  output logic [EMPTY_WIDTH-1:0]   avst_empty_o,
  output logic                     avst_sop_o,
  output logic                     avst_eop_o,
  input  logic                     avst_ready_i
);

  localparam int unsigned W   = WIDTH * WORDS;
  localparam int unsigned BPB = W / 8;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t      state;
  logic [15:0] len_r;
  logic [15:0] nb_r;
  logic [31:0] cnt_r;
  logic [7:0]  ipg_r;
  logic [7:0]  pkt_idx;
  logic [15:0] beat;
  logic [7:0]  gap_cnt;
  logic        stop_pend;

  function automatic logic [15:0] beats_of(input logic [15:0] len);
    return 16'((32'(len) + BPB - 1) / BPB);
  endfunction

  function automatic logic [EMPTY_WIDTH-1:0] eop_empty(input logic [15:0] len);
    logic [31:0] rem;
    rem = 32'(len) % BPB;
    return (rem == 32'd0) ? '0 : EMPTY_WIDTH'(BPB - rem);
  endfunction

  // Byte k of a frame is (index + k) mod 256, MSB byte first; bytes past len are 0.
  function automatic logic [W-1:0] beat_data(input logic [7:0] idx, input logic [15:0] b,
                                             input logic [15:0] len);
    logic [W-1:0] d;
    logic [31:0]  off;
    d = '0;
    for (int j = 0; j < int'(BPB); j++) begin
      off = 32'(b) * BPB + 32'(j);
      if (off < 32'(len)) d[W-1-8*j -: 8] = idx + off[7:0];
    end
    return d;
  endfunction

  // Next beat to present, whichever state we are loading it from.
  logic [7:0]             ld_idx;
  logic [15:0]            ld_beat;
  logic [15:0]            ld_len;
  logic [15:0]            ld_nb;
  logic                   ld_last;
  logic [W-1:0]           ld_data;
  logic [EMPTY_WIDTH-1:0] ld_empty;
  logic                   run_end;

  always_comb begin
    ld_idx  = pkt_idx;
    ld_beat = beat + 16'd1;
    ld_len  = len_r;
    ld_nb   = nb_r;
    case (state)
      IDLE: begin
        ld_idx  = '0;
        ld_beat = '0;
        ld_len  = pkt_len_i;
        ld_nb   = beats_of(pkt_len_i);
      end
      SEND: if (avst_eop_o) begin
        ld_idx  = pkt_idx + 8'd1;
        ld_beat = '0;
      end
      GAP:  ld_beat = '0;
      default: ;
    endcase
    ld_last  = (ld_beat == ld_nb - 16'd1);
    ld_data  = beat_data(ld_idx, ld_beat, ld_len);
    ld_empty = ld_last ? eop_empty(ld_len) : '0;
    run_end  = ((cnt_r != 32'd0) && (pkt_sent_o + 32'd1 == cnt_r)) || stop_pend || stop_i;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state        <= IDLE;
      len_r        <= '0;
      nb_r         <= '0;
      cnt_r        <= '0;
      ipg_r        <= '0;
      pkt_idx      <= '0;
      beat         <= '0;
      gap_cnt      <= '0;
      stop_pend    <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      pkt_sent_o   <= '0;
      byte_sent_o  <= '0;
      avst_valid_o <= 1'b0;
      avst_data_o  <= '0;
      avst_empty_o <= '0;
      avst_sop_o   <= 1'b0;
      avst_eop_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: if (start_i && pkt_len_i != 16'd0) begin
          len_r        <= pkt_len_i;
          nb_r         <= ld_nb;
          cnt_r        <= pkt_cnt_i;
          ipg_r        <= ipg_i;
          pkt_idx      <= '0;
          beat         <= '0;
          stop_pend    <= 1'b0;
          pkt_sent_o   <= '0;
          byte_sent_o  <= '0;
          busy_o       <= 1'b1;
          state        <= SEND;
          avst_valid_o <= 1'b1;
          avst_data_o  <= ld_data;
          avst_empty_o <= ld_empty;
          avst_sop_o   <= 1'b1;
          avst_eop_o   <= ld_last;
        end
        SEND: begin
          if (stop_i) stop_pend <= 1'b1;
          if (avst_valid_o && avst_ready_i) begin
            if (avst_eop_o) begin
              pkt_sent_o  <= pkt_sent_o + 32'd1;
              byte_sent_o <= byte_sent_o + 48'(len_r);
              pkt_idx     <= pkt_idx + 8'd1;
            end
            if (avst_eop_o && (run_end || ipg_r != 8'd0)) begin
              avst_valid_o <= 1'b0;
              avst_data_o  <= '0;
              avst_empty_o <= '0;
              avst_sop_o   <= 1'b0;
              avst_eop_o   <= 1'b0;
              if (run_end) begin
                state     <= IDLE;
                busy_o    <= 1'b0;
                done_o    <= 1'b1;
                stop_pend <= 1'b0;
              end else begin
                state   <= GAP;
                gap_cnt <= ipg_r;
              end
            end else begin
              beat         <= ld_beat;
              avst_data_o  <= ld_data;
              avst_empty_o <= ld_empty;
              avst_sop_o   <= (ld_beat == 16'd0);
              avst_eop_o   <= ld_last;
            end
          end
        end
        GAP: begin
          if (stop_i) begin
            state     <= IDLE;
            busy_o    <= 1'b0;
            done_o    <= 1'b1;
            stop_pend <= 1'b0;
          end else if (gap_cnt == 8'd1) begin
            state        <= SEND;
            beat         <= '0;
            avst_valid_o <= 1'b1;
            avst_data_o  <= ld_data;
            avst_empty_o <= ld_empty;
            avst_sop_o   <= 1'b1;
            avst_eop_o   <= ld_last;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avst_pkt_gen.sv
// Randomized self-checking bench for avst_pkt_gen: frames are predicted as byte
// streams from the run parameters and compared beat by beat against the DUT.
module tb_avst_pkt_gen;

  localparam int WORDS       = 1;
  localparam int WIDTH       = 64;
  localparam int EMPTY_WIDTH = 3;
  localparam int BPB         = WIDTH * WORDS / 8;

  logic                   aclk = 1'b0;
  logic                   areset;
  logic                   start_i;
  logic                   stop_i;
  logic [15:0]            pkt_len_i;
  logic [31:0]            pkt_cnt_i;
  logic [7:0]             ipg_i;
  logic                   busy_o;
  logic                   done_o;
  logic [31:0]            pkt_sent_o;
  logic [47:0]            byte_sent_o;
  logic                   avst_valid_o;
  logic [WIDTH*WORDS-1:0] avst_data_o;
  logic [EMPTY_WIDTH-1:0] avst_empty_o;
  logic                   avst_sop_o;
  logic                   avst_eop_o;
  logic                   avst_ready_i;

  int n_checks = 0;
  int n_errors = 0;

  avst_pkt_gen #(.WORDS(WORDS), .WIDTH(WIDTH), .EMPTY_WIDTH(EMPTY_WIDTH)) dut (
    .aclk(aclk), .areset(areset), .start_i(start_i), .stop_i(stop_i),
    .pkt_len_i(pkt_len_i), .pkt_cnt_i(pkt_cnt_i), .ipg_i(ipg_i),
    .busy_o(busy_o), .done_o(done_o), .pkt_sent_o(pkt_sent_o), .byte_sent_o(byte_sent_o),
    .avst_valid_o(avst_valid_o), .avst_data_o(avst_data_o), .avst_empty_o(avst_empty_o),
    .avst_sop_o(avst_sop_o), .avst_eop_o(avst_eop_o), .avst_ready_i(avst_ready_i)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_valid"}, avst_valid_o, 0);
    chk({tag, "_sop"}, avst_sop_o, 0);
    chk({tag, "_eop"}, avst_eop_o, 0);
    chk({tag, "_data"}, avst_data_o, 0);
    chk({tag, "_empty"}, avst_empty_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_pkt_sent"}, pkt_sent_o, 0);
    chk({tag, "_byte_sent"}, byte_sent_o, 0);
  endtask

  // rmode: 0 ready always high, 1 pattern 1,0,0 repeating, 2 random.
  // stop_frame: pulse stop on the sop beat of that frame (-1 none).
  // gap_stop: pulse stop in the first gap cycle after that frame (-1 none).
  // rst_frame: assert reset on beat 3 of that frame (-1 none).
  task automatic run(input int len, input int cnt, input int ipg, input int rmode,
                     input int stop_frame, input int gap_stop, input int rst_frame,
                     input bit start_with_stop);
    int          frames = 0;
    longint      bytes = 0;
    int          off = 0;
    int          gap_left = 0;
    int          rcnt = 0;
    bit          pend_done = 0;
    bit          stop_pend = 0;
    bit          ended = 0;
    bit          was_reset = 0;
    bit          rdy;
    bit          eeop;
    int          emp;
    logic [63:0] ed;
    @(negedge aclk);
    pkt_len_i = 16'(len);
    pkt_cnt_i = 32'(cnt);
    ipg_i     = 8'(ipg);
    start_i   = 1'b1;
    stop_i    = start_with_stop;
    for (int cyc = 0; cyc < 4000 && !ended; cyc++) begin
      @(negedge aclk);
      start_i   = 1'b0;
      stop_i    = 1'b0;
      pkt_len_i = 16'($urandom);
      chk("done", done_o, pend_done);
      chk("pkt_sent", pkt_sent_o, 64'(frames));
      chk("byte_sent", byte_sent_o, 64'(bytes[47:0]));
      if (pend_done) begin
        chk("busy_end", busy_o, 0);
        chk("valid_end", avst_valid_o, 0);
        ended = 1;
      end else begin
        chk("busy", busy_o, 1);
        if (gap_left > 0) begin
          chk("gap_valid", avst_valid_o, 0);
          if (gap_stop == frames - 1 && gap_left == ipg) begin
            stop_i    = 1'b1;
            pend_done = 1;
          end
          gap_left--;
        end else begin
          ed  = '0;
          emp = 0;
          for (int j = 0; j < BPB; j++) begin
            if (off + j < len) ed[63-8*j -: 8] = 8'((frames + off + j) % 256);
            else emp++;
          end
          eeop = (off + BPB >= len);
          chk("valid", avst_valid_o, 1);
          chk("data", avst_data_o, ed);
          chk("sop", avst_sop_o, 64'(off == 0));
          chk("eop", avst_eop_o, 64'(eeop));
          chk("empty", avst_empty_o, 64'(eeop ? emp : 0));
          if (rst_frame == frames && off == 3 * BPB) begin
            areset       = 1'b1;
            avst_ready_i = 1'($urandom);
            @(negedge aclk);
            chk_idle_zero("rst");
            areset    = 1'b0;
            ended     = 1;
            was_reset = 1;
          end else begin
            if (stop_frame == frames && off == 0 && !eeop) begin
              stop_i    = 1'b1;
              stop_pend = 1;
            end
            case (rmode)
              0:       rdy = 1'b1;
              1:       rdy = (rcnt % 3 == 0);
              default: rdy = 1'($urandom);
            endcase
            rcnt++;
            avst_ready_i = rdy;
            if (rdy) begin
              if (eeop) begin
                frames++;
                bytes += len;
                off = 0;
                if ((cnt != 0 && frames == cnt) || stop_pend) pend_done = 1;
                else gap_left = ipg;
              end else begin
                off += BPB;
              end
            end
            if (!pend_done && $urandom_range(0, 7) == 0) start_i = 1'b1;
          end
        end
      end
    end
    if (!ended) chk("timeout", 0, 1);
    else if (!was_reset) begin
      @(negedge aclk);
      chk("done_once", done_o, 0);
      chk("busy_idle", busy_o, 0);
      chk("pkt_sent_hold", pkt_sent_o, 64'(frames));
    end
  endtask

  initial begin
    areset       = 1'b1;
    start_i      = 1'b0;
    stop_i       = 1'b0;
    pkt_len_i    = '0;
    pkt_cnt_i    = '0;
    ipg_i        = '0;
    avst_ready_i = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk_idle_zero("reset");
    areset = 1'b0;

    // Zero-length start is ignored.
    @(negedge aclk);
    pkt_len_i = '0;
    pkt_cnt_i = 32'd1;
    start_i   = 1'b1;
    @(negedge aclk);
    start_i = 1'b0;
    chk("len0_busy", busy_o, 0);
    chk("len0_valid", avst_valid_o, 0);

    run(64, 1, 0, 0, -1, -1, -1, 0);
    run(61, 2, 0, 0, -1, -1, -1, 0);
    run(5, 3, 0, 0, -1, -1, -1, 0);
    run(64, 1, 0, 1, -1, -1, -1, 0);
    run(16, 0, 4, 0, 2, -1, -1, 0);
    run(16, 0, 3, 2, -1, 1, -1, 0);
    run(64, 0, 0, 0, -1, -1, 2, 0);
    run(64, 1, 0, 0, -1, -1, -1, 0);
    run(1, 2, 1, 2, -1, -1, -1, 1);
    for (int t = 0; t < 15; t++) begin
      run(($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 300)) : int'($urandom_range(1, 40)),
          int'($urandom_range(1, 4)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
          -1, -1, -1, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/avst_pkt_gen.md
# avst_pkt_gen

Synthetic Ethernet frame source for the CVL BFM TX path. It drives the Avalon-ST side of the AVST-to-AXI-S bridge with a programmable number of frames of programmable length, a deterministic payload, and a programmable inter-packet gap. It honours backpressure and reports progress counters, so benches can generate line-rate or throttled traffic without a software model.

## Interface
- WORDS, 1: words per beat; must match the downstream bridge.
- WIDTH, 64: bits per word. BPB = WIDTH*WORDS/8 bytes per beat.
- EMPTY_WIDTH, 3: width of `avst_empty_o`; must be ≥ clog2(BPB).

Ports:
- `aclk` in 1: the only clock.
- `areset` in 1: synchronous, active-high reset.
- `start_i` in 1: single-cycle pulse that begins a run. Ignored while `busy_o`=1 or when `pkt_len_i`=0.
- `stop_i` in 1: pulse requesting a graceful stop. The frame in progress completes.
- `pkt_len_i` in 16: frame length in bytes, 1..65535. Sampled on `start_i`.
- `pkt_cnt_i` in 32: number of frames in the run; 0 means continuous. Sampled on `start_i`.
- `ipg_i` in 8: idle cycles between frames. Sampled on `start_i`.
- `busy_o` out 1: high from the cycle after an accepted start until the run ends.
- `done_o` out 1: one-cycle pulse when the run ends (count reached or stop).
- `pkt_sent_o` out 32: frames completed in the current run.
- `byte_sent_o` out 48: payload bytes accepted in the current run.
- `avst_valid_o` out 1: Avalon-ST valid.
- `avst_data_o` out WIDTH*WORDS: beat data. Byte 0 of the beat is in the MSB byte, [W-1 -: 8].
- `avst_empty_o` out EMPTY_WIDTH: count of unused bytes on the eop beat; 0 on all other beats.
- `avst_sop_o` out 1: start of packet.
- `avst_eop_o` out 1: end of packet.
- `avst_ready_i` in 1: downstream ready, ready latency 0.

## Operation
- FSM states are IDLE, SEND and GAP.
- IDLE:
  - On a valid `start_i`, latch len, cnt and ipg.
  - Clear `pkt_sent_o` and `byte_sent_o`, set the packet index to 0, and go to SEND.
- SEND:
  - Beats per frame: NB = ceil(len/BPB).
  - The beat counter b runs from 0 to NB-1. sop is asserted when b=0 and eop when b=NB-1. The eop beat carries empty = NB*BPB - len. A one-beat frame has sop and eop together.
  - Payload: the byte at frame offset k equals (packet_index[7:0] + k) mod 256. Bytes in the empty positions (LSB end) are driven to 0.
  - A beat advances only when valid & ready.
  - When the eop beat is accepted:
    - Increment `pkt_sent_o` and the packet index.
    - Add len to `byte_sent_o`.
    - The run ends if the frame count is met (cnt≠0) or a stop is pending: go to IDLE and pulse `done_o`.
    - Otherwise go to GAP if ipg>0, or start the next frame's sop beat if ipg=0.
- GAP: `avst_valid_o`=0 for exactly ipg cycles, then go to SEND.
- `stop_i`:
  - Recorded as pending in any non-IDLE state.
  - In GAP it ends the run at the next cycle: go to IDLE and pulse `done_o`.
  - In IDLE it is ignored.
- Counter arithmetic is modulo 2^32 and 2^48 respectively; wrap-around is silent.

## Timing
- Reset values:
  - `avst_valid_o`, `avst_sop_o`, `avst_eop_o`, `busy_o` and `done_o` are 0.
  - `avst_data_o`, `avst_empty_o`, `pkt_sent_o` and `byte_sent_o` are 0.
  - The FSM is in IDLE and any pending stop is cleared.
- Reset mid-frame: `avst_valid_o` is 0 on the cycle after the reset edge. The frame is abandoned with no eop; this truncation is accepted bench behaviour.
- Start latency: `start_i` sampled at edge t gives `avst_valid_o`=1 with sop on the cycle after edge t. `busy_o` rises in that same cycle.
- Outputs are registered.
- While `avst_ready_i`=0, data, sop, eop and empty are held stable with valid high. Valid never drops mid-frame.
- With ipg=0 and ready held high, the next frame's sop follows the eop beat in the very next cycle, with no bubble.
- `pkt_sent_o` and `byte_sent_o` update the cycle after eop is accepted.
- `done_o` and the falling edge of `busy_o` occur the cycle after the final eop is accepted, or after a stop taken in GAP.
- `start_i` and `stop_i` in the same IDLE cycle: the start is accepted and the stop is ignored.
- `start_i` while busy is dropped with no effect.

## Test plan
- Single frame, BPB=8:
  - Stimulus: len=64, cnt=1, ipg=0, ready=1.
  - Required: 8 beats, sop on beat 0, eop on beat 7, empty=0. Beat 0 data = 0x0001020304050607. `pkt_sent_o`=1, `byte_sent_o`=64, `done_o` pulses once.
- Partial last beat:
  - Stimulus: len=61, cnt=2.
  - Required: each frame is 8 beats with empty=3 on eop. Frame 1 starts with byte 0x01. The empty bytes are 0. `byte_sent_o`=122.
- One-beat frame and back-to-back:
  - Stimulus: len=5, cnt=3, ipg=0.
  - Required: 3 consecutive valid cycles, each with sop=eop=1 and empty=3, with no idle cycle between them.
- Backpressure:
  - Stimulus: len=64; ready toggles with pattern 1,0,0,1,…
  - Required: beats are held stable while ready=0. The frame completes with exactly 8 accepted beats and the payload sequence intact.
- IPG and stop:
  - Stimulus: len=16, cnt=0, ipg=4. Assert `stop_i` during the third frame.
  - Required: 4 valid-low cycles between frames. The third frame completes, then `done_o` pulses and `pkt_sent_o`=3.
- Reset mid-frame:
  - Stimulus: assert `areset` on beat 3 of a 64-byte frame.
  - Required: valid=0 on the next cycle and all counters read 0. A new start then begins a fresh frame at index 0.
